// File: rtl/button_conditioner_pkg.sv
// Shared types and width helpers for the button conditioner.
package button_conditioner_pkg;

  // Per-channel debounce FSM encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMING  = 2'b01,
    PRESSED = 2'b10
  } chan_state_e;

  // Tick counter width: holds 0..sample_max-1.
  function automatic int unsigned tick_cnt_w(input int unsigned sample_max);
    return (sample_max < 2) ? 1 : $clog2(sample_max);
  endfunction

  // Saturating counter width: holds 0..cnt_max inclusive.
  function automatic int unsigned sat_cnt_w(input int unsigned cnt_max);
    return (cnt_max < 1) ? 1 : $clog2(cnt_max + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debounce FSM paced by the shared sample tick.
// Optional auto-repeat while held: BUTTON_CONDITIONER_REPEAT_EN.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned PULSE_CNT_MAX = 200
`ifdef BUTTON_CONDITIONER_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = 1000,
  parameter int unsigned REPEAT_PERIOD = 200
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_tick,
  input  logic sync_in,
  output logic debounced,
  output logic rise_pulse
);

  localparam int unsigned CNT_W = sat_cnt_w(PULSE_CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_CNT_MAX);

  chan_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             deb_nxt;
  logic             pulse_nxt;

`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam int unsigned HOLD_W = sat_cnt_w(REPEAT_DELAY);
  localparam int unsigned PER_W  = sat_cnt_w(REPEAT_PERIOD);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_DELAY);
  localparam logic [PER_W-1:0]  PER_ONE   = PER_W'(1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(REPEAT_PERIOD);

  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [PER_W-1:0]  per_cnt, per_nxt;
`endif

  // State, counters and output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      debounced  <= 1'b0;
      rise_pulse <= 1'b0;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
      hold_cnt   <= '0;
      per_cnt    <= '0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      debounced  <= deb_nxt;
      rise_pulse <= pulse_nxt;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
      hold_cnt   <= hold_nxt;
      per_cnt    <= per_nxt;
`endif
    end
  end

  // Next-state logic; everything holds between ticks, pulse defaults low.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    deb_nxt   = debounced;
    pulse_nxt = 1'b0;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
    hold_nxt  = hold_cnt;
    per_nxt   = per_cnt;
`endif
    if (sample_tick) begin
      case (state)
        IDLE: begin
          if (sync_in) begin
            cnt_nxt   = CNT_ONE;
            state_nxt = ARMING;
          end
        end
        ARMING: begin
          if (!sync_in) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else if (cnt + CNT_ONE >= CNT_LAST) begin
            cnt_nxt   = CNT_LAST;
            state_nxt = PRESSED;
            deb_nxt   = 1'b1;
            pulse_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sync_in) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
            deb_nxt   = 1'b0;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
            hold_nxt  = '0;
            per_nxt   = '0;
          end else if (hold_cnt != HOLD_LAST) begin
            // Still inside the initial delay window.
            hold_nxt = hold_cnt + HOLD_ONE;
            if (hold_cnt + HOLD_ONE == HOLD_LAST) begin
              pulse_nxt = 1'b1;
            end
          end else if (per_cnt + PER_ONE >= PER_LAST) begin
            per_nxt   = '0;
            pulse_nxt = 1'b1;
          end else begin
            per_nxt = per_cnt + PER_ONE;
`endif
          end
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          deb_nxt   = 1'b0;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
          hold_nxt  = '0;
          per_nxt   = '0;
`endif
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Synchronizes and debounces WIDTH raw button inputs; emits clean levels
// and one-cycle press pulses. Optional auto-repeat: BUTTON_CONDITIONER_REPEAT_EN.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned WIDTH          = 1,
  parameter int unsigned SAMPLE_CNT_MAX = 62500,
  parameter int unsigned PULSE_CNT_MAX  = 200,
  parameter int unsigned REPEAT_DELAY   = 1000,
  parameter int unsigned REPEAT_PERIOD  = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] rise_pulse,
  output logic             sample_tick
);

  localparam int unsigned TICK_W = tick_cnt_w(SAMPLE_CNT_MAX);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_CNT_MAX - 1);

  // Reject configurations the counters cannot represent.
  if (SAMPLE_CNT_MAX < 2 || PULSE_CNT_MAX < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_conditioner: illegal parameter set");
  end

  logic [WIDTH-1:0]  sync_q1, sync_q2;
  logic [TICK_W-1:0] tick_cnt, tick_cnt_nxt;

  // Two-flop synchronizer per input bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= async_in;
      sync_q2 <= sync_q1;
    end
  end

  // Wrapping sample counter next value.
  always_comb begin
    tick_cnt_nxt = tick_cnt + TICK_W'(1);
    if (tick_cnt == TICK_LAST) begin
      tick_cnt_nxt = '0;
    end
  end

  // Tick flop is high exactly while the count sits at its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt    <= '0;
      sample_tick <= 1'b0;
    end else begin
      tick_cnt    <= tick_cnt_nxt;
      sample_tick <= (tick_cnt_nxt == TICK_LAST);
    end
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
    debounce_channel #(
      .PULSE_CNT_MAX (PULSE_CNT_MAX)
`ifdef BUTTON_CONDITIONER_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample_tick (sample_tick),
      .sync_in     (sync_q2[i]),
      .debounced   (debounced[i]),
      .rise_pulse  (rise_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner with a run-length reference model.
module tb_button_conditioner;

  localparam int unsigned W  = 4;
  localparam int unsigned S  = 4;
  localparam int unsigned P  = 3;
  localparam int unsigned RD = 5;
  localparam int unsigned RP = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] async_in;
  logic [W-1:0] debounced;
  logic [W-1:0] rise_pulse;
  logic         sample_tick;

  always #5 clk = ~clk;

  button_conditioner #(
    .WIDTH          (W),
    .SAMPLE_CNT_MAX (S),
    .PULSE_CNT_MAX  (P),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .async_in    (async_in),
    .debounced   (debounced),
    .rise_pulse  (rise_pulse),
    .sample_tick (sample_tick)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: consecutive-high sample run length per channel.
  int           run [W];
  logic [W-1:0] h0, h1;
  logic [W-1:0] exp_deb, exp_pulse;
  logic         exp_tick;
  int           edges;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // A pulse is due on acceptance and on each auto-repeat point while held.
  function automatic bit pulse_due(input int r);
    if (r == int'(P)) return 1'b1;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
    if (r - int'(P) >= int'(RD) && ((r - int'(P) - int'(RD)) % int'(RP)) == 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(W); i++) run[i] = 0;
    h0 = '0; h1 = '0;
    exp_deb = '0; exp_pulse = '0;
    exp_tick = 1'b0;
    edges = 0;
  endtask

  // Advance the model by one rising edge with input a applied.
  task automatic model_edge(input logic [W-1:0] a);
    logic [W-1:0] s;
    s = h1;
    exp_pulse = '0;
    if (exp_tick) begin
      for (int i = 0; i < int'(W); i++) begin
        run[i]       = s[i] ? run[i] + 1 : 0;
        exp_deb[i]   = (run[i] >= int'(P));
        exp_pulse[i] = s[i] && pulse_due(run[i]);
      end
    end
    h1 = h0;
    h0 = a;
    edges++;
    exp_tick = ((edges % int'(S)) == int'(S) - 1);
  endtask

  // One clock with input a; called and returns at a falling edge.
  task automatic step(input logic [W-1:0] a);
    async_in = a;
    @(posedge clk);
    model_edge(a);
    @(negedge clk);
    check("debounced",   32'(debounced),   32'(exp_deb));
    check("rise_pulse",  32'(rise_pulse),  32'(exp_pulse));
    check("sample_tick", 32'(sample_tick), 32'(exp_tick));
  endtask

  task automatic hold(input logic [W-1:0] a, input int n);
    for (int k = 0; k < n; k++) step(a);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_deb"},   32'(debounced),   32'd0);
    check({tag, "_pulse"}, 32'(rise_pulse),  32'd0);
    check({tag, "_tick"},  32'(sample_tick), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    int           seg_left [W];
    logic [W-1:0] lvl;
    bit           reached;

    // Inputs high throughout reset: outputs must stay zero.
    rst_n    = 1'b0;
    async_in = '1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_zero("in_reset");
    end
    rst_n = 1'b1;

    // Input already high at release, then release and idle.
    hold('1, 24);
    hold('0, 12);

    // Clean press on channel 0, then release.
    hold(4'b0001, 40);
    hold(4'b0000, 12);

    // Bounce and a between-tick glitch, then a steady press.
    hold(4'b0001, 8);
    hold(4'b0000, 5);
    hold(4'b0001, 1);
    hold(4'b0000, 6);
    hold(4'b0001, 24);
    hold(4'b0000, 10);

    // Staggered presses on bits 0 and 2, simultaneous on 1 and 3.
    hold(4'b0001, 6);
    hold(4'b0101, 9);
    hold(4'b1111, 30);
    hold(4'b1010, 10);
    hold(4'b0000, 10);

    // Long hold to exercise auto-repeat when enabled.
    hold(4'b0001, 80);
    hold(4'b0000, 10);

    // Reset while channel 0 is arming with two samples collected.
    reached = 1'b0;
    for (int k = 0; k < 40 && !reached; k++) begin
      step(4'b0001);
      reached = (run[0] == 2);
    end
    check("arm_wait_reached", 32'(reached), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_zero("mid_reset");
    end
    rst_n = 1'b1;
    model_reset();
    hold(4'b0001, 30);
    hold(4'b0000, 8);

    // Randomized segments with occasional single-cycle glitches.
    for (int i = 0; i < int'(W); i++) seg_left[i] = 0;
    lvl = '0;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < int'(W); i++) begin
        if (seg_left[i] == 0) begin
          lvl[i]      = 1'($urandom_range(0, 1));
          seg_left[i] = lvl[i] ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 18));
        end
        seg_left[i]--;
      end
      v = lvl;
      if ($urandom_range(0, 19) == 0) v[$urandom_range(0, W - 1)] ^= 1'b1;
      step(v);
    end
    hold('0, 12);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end controller for WIDTH raw, asynchronous push-button or switch inputs.
- Synchronizes each input with a 2-flop stage, then debounces it with a per-channel FSM paced by one shared sample-tick counter.
- Emits a clean level and a single-cycle press pulse per channel.
- Sits between the board I/O pins and all user logic that consumes button events.

Parameters:
- WIDTH, 1, number of independent input channels.
- SAMPLE_CNT_MAX, 62500, clk cycles per sample tick; must be >= 2.
- PULSE_CNT_MAX, 200, consecutive high samples required to accept a press; must be >= 2.
- REPEAT_DELAY, 1000, held ticks before the first auto-repeat pulse; used only with the optional feature.
- REPEAT_PERIOD, 200, ticks between auto-repeat pulses; used only with the optional feature.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- async_in  input  WIDTH  raw unsynchronized inputs, active-high.
- debounced  output  WIDTH  debounced level per channel.
- rise_pulse  output  WIDTH  one-clk pulse per accepted press (and per auto-repeat, if enabled).
- sample_tick  output  1  shared sample strobe, exported for debug and bench use.

Behaviour:
- Reset: while rst_n=0, all of the following are forced to 0 immediately (asynchronously): synchronizer flops, tick counter, channel counters, debounced, rise_pulse, sample_tick. All FSMs go to IDLE.
- Synchronizer:
  - 2 flops per bit.
  - async_in reaches the internal sync signal 2 clk edges after being sampled.
- Tick counter:
  - Width $clog2(SAMPLE_CNT_MAX); counts 0..SAMPLE_CNT_MAX-1, then wraps to 0.
  - sample_tick is registered and is high for exactly the one cycle in which the count equals SAMPLE_CNT_MAX-1.
  - First tick comes SAMPLE_CNT_MAX cycles after reset release.
- Per-channel FSM, 2-bit state: IDLE, ARMING, PRESSED.
  - State and counter change only in cycles where sample_tick=1; between ticks everything holds.
  - Sync input activity between ticks is ignored.
  - Counter width $clog2(PULSE_CNT_MAX+1); it saturates and never wraps.
- IDLE:
  - Tick with sync=1: cnt <= 1, go to ARMING.
  - Tick with sync=0: stay in IDLE.
- ARMING:
  - Tick with sync=1 and cnt+1 < PULSE_CNT_MAX: cnt++.
  - Tick with sync=1 and cnt+1 == PULSE_CNT_MAX: go to PRESSED; debounced <= 1; rise_pulse <= 1 for one cycle.
  - Tick with sync=0: cnt <= 0, go to IDLE; no pulse (bounce rejected).
- PRESSED:
  - Tick with sync=0: go to IDLE, debounced <= 0, cnt <= 0. Release is accepted on a single low sample.
  - Tick with sync=1: stay in PRESSED.
- Output timing: debounced and rise_pulse are registered and update on the edge after the deciding tick cycle.
  - rise_pulse is never high for two consecutive cycles.
- Latency: from async_in rising to rise_pulse, worst case is 2 + PULSE_CNT_MAX*SAMPLE_CNT_MAX + 1 clk cycles.
- Channels are fully independent. Simultaneous presses on several channels may pulse in the same cycle.
- Reset mid-operation: an input held high through reset release must again collect a full PULSE_CNT_MAX samples before it is accepted.

Optional Feature:
- Macro: BUTTON_CONDITIONER_REPEAT_EN.
- Defined:
  - PRESSED keeps a per-channel hold counter that counts ticks.
  - rise_pulse fires again when the hold count reaches REPEAT_DELAY, then every REPEAT_PERIOD ticks while the input stays held.
  - The hold counter clears on leaving PRESSED and on reset.
- Undefined:
  - Exactly one rise_pulse per press.
  - No hold counter is synthesized; REPEAT_* parameters are ignored.

Decomposition:
- Shared package/header button_conditioner_pkg holds:
  - state encodings IDLE=2'b00, ARMING=2'b01, PRESSED=2'b10;
  - clog2-based counter-width constants.
- Sub-module debounce_channel: one FSM, counter and output flops for a single bit, instantiated WIDTH times via generate.
- Tick counter and synchronizer stay in the top level.

Test Plan:
1. Parameters WIDTH=1, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3; hold rst_n=0 with async_in=1 -> debounced=0, rise_pulse=0, sample_tick=0 throughout. After release, the first sample_tick is seen 4 cycles later.
2. Clean press, async_in=1 held for 40 cycles -> exactly one rise_pulse, within 15 cycles of the input rise; debounced=1 until 1 tick after async_in returns to 0.
3. Bounce: high for 2 ticks, low at the 3rd, plus a 1-cycle glitch between ticks -> no rise_pulse, debounced stays 0. A following steady high -> pulse after 3 further ticks.
4. WIDTH=4, staggered presses on bits 0 and 2 plus a simultaneous press on bits 1 and 3 -> independent pulses; bits 1 and 3 pulse in the same cycle.
5. rst_n pulsed low while a channel is in ARMING with cnt=2 -> outputs 0 immediately. Input still high after release -> pulse only after 3 new ticks.
6. BUTTON_CONDITIONER_REPEAT_EN defined, REPEAT_DELAY=5, REPEAT_PERIOD=2, input held for 12 ticks past PRESSED -> rise_pulse at entry and at hold ticks 5, 7, 9, 11.
